// File: rtl/sigma_np.sv
// sigma_np -- block accumulator for a strobed sample stream.
//
// Each rising edge of syn_in takes one sample from data_in, converts it from
// sign-magnitude or two's complement to a signed OUT_W value, and adds it to a
// running sum. After 2^len samples the full block sum is presented on data_out
// with a one-cycle syn_out pulse, and the accumulator restarts.
//
// Optional feature: define SIGMA_NP_MEAN_EN to add mean_out, the rounded block
// mean, registered together with data_out.
//
// Ports:
//   clk      in   clock, rising edge
//   res      in   asynchronous active-high reset
//   data_in  in   [DATA_W]   sample value
//   syn_in   in   sample strobe, one sample per rising edge
//   fmt_sm   in   1 = sign-magnitude, 0 = two's complement
//   log2_n   in   [LW]       requested block length as log2
//   clr      in   synchronous block restart
//   data_out out  [OUT_W]    two's-complement block sum
//   syn_out  out  one-cycle pulse marking a new data_out
//   mean_out out  [DATA_W+1] rounded block mean (SIGMA_NP_MEAN_EN only)
module sigma_np #(
  parameter int DATA_W     = 8,
  parameter int LOG2_N_MAX = 4,
  localparam int OUT_W     = DATA_W + LOG2_N_MAX,
  localparam int LW        = $clog2(LOG2_N_MAX + 1)
) (
  input  logic              clk,
  input  logic              res,
  input  logic [DATA_W-1:0] data_in,
  input  logic              syn_in,
  input  logic              fmt_sm,
  input  logic [LW-1:0]     log2_n,
  input  logic              clr,
  output logic [OUT_W-1:0]  data_out,
  output logic              syn_out
`ifdef SIGMA_NP_MEAN_EN
  ,
  output logic [DATA_W:0]   mean_out
`endif
);

  localparam int CNT_W = (LOG2_N_MAX > 0) ? LOG2_N_MAX : 1;

  // Sample conversion to a signed OUT_W value. Sign-magnitude -0 yields 0
  // because negating a zero magnitude is still zero.
  function automatic logic signed [OUT_W-1:0] to_sample(
    input logic [DATA_W-1:0] d,
    input logic              sm
  );
    logic signed [OUT_W-1:0] mag;
    mag = {{(OUT_W-DATA_W+1){1'b0}}, d[DATA_W-2:0]};
    if (sm) begin
      return d[DATA_W-1] ? -mag : mag;
    end
    return {{(OUT_W-DATA_W){d[DATA_W-1]}}, d};
  endfunction

`ifdef SIGMA_NP_MEAN_EN
  // Rounded mean: add half an LSB of the result, then arithmetic shift.
  // Worked one bit wider than the sum so the bias cannot wrap.
  function automatic logic [DATA_W:0] round_mean(
    input logic signed [OUT_W-1:0] s,
    input logic [LW-1:0]           l
  );
    logic signed [OUT_W:0] wide;
    logic signed [OUT_W:0] bias;
    wide = {s[OUT_W-1], s};
    bias = '0;
    if (l != '0) begin
      bias = (OUT_W+1)'(1) << (l - LW'(1));
    end
    wide = (wide + bias) >>> l;
    return wide[DATA_W:0];
  endfunction
`endif

  logic                    syn_d;
  logic signed [OUT_W-1:0] sigma;
  logic [CNT_W-1:0]        count;
  logic [LW-1:0]           len_q;

  logic                    pulse;
  logic [LW-1:0]           len_lim;
  logic [LW-1:0]           len_eff;
  logic [CNT_W:0]          blk_n;
  logic                    last;
  logic signed [OUT_W-1:0] sample;
  logic signed [OUT_W-1:0] sum_next;

  assign pulse   = syn_in & ~syn_d;
  assign len_lim = (log2_n > LW'(LOG2_N_MAX)) ? LW'(LOG2_N_MAX) : log2_n;
  // At the start of a block the freshly requested length applies to the
  // first sample too; once the block is running the latched length is frozen.
  assign len_eff  = (count == '0) ? len_lim : len_q;
  assign blk_n    = (CNT_W+1)'(1) << len_eff;
  assign last     = ({1'b0, count} == (blk_n - (CNT_W+1)'(1)));
  assign sample   = to_sample(data_in, fmt_sm);
  assign sum_next = sigma + sample;

  // Stage boundary: strobe edge, accumulate, publish completed block
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      syn_d    <= 1'b0;
      sigma    <= '0;
      count    <= '0;
      len_q    <= '0;
      data_out <= '0;
      syn_out  <= 1'b0;
`ifdef SIGMA_NP_MEAN_EN
      mean_out <= '0;
`endif
    end else begin
      syn_d   <= syn_in;
      syn_out <= 1'b0;
      if (count == '0) begin
        len_q <= len_lim;
      end
      if (clr) begin
        // Restart wins over a coincident strobe; the strobe is consumed.
        sigma <= '0;
        count <= '0;
      end else if (pulse) begin
        if (last) begin
          data_out <= sum_next;
          sigma    <= '0;
          count    <= '0;
          syn_out  <= 1'b1;
`ifdef SIGMA_NP_MEAN_EN
          mean_out <= round_mean(sum_next, len_eff);
`endif
        end else begin
          sigma <= sum_next;
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sigma_np.sv
module tb_sigma_np;

  localparam int DATA_W     = 8;
  localparam int LOG2_N_MAX = 4;
  localparam int OUT_W      = DATA_W + LOG2_N_MAX;
  localparam int LW         = $clog2(LOG2_N_MAX + 1);

  logic              clk = 1'b0;
  logic              res = 1'b1;
  logic [DATA_W-1:0] data_in = '0;
  logic              syn_in = 1'b0;
  logic              fmt_sm = 1'b0;
  logic [LW-1:0]     log2_n = '0;
  logic              clr = 1'b0;
  logic [OUT_W-1:0]  data_out;
  logic              syn_out;
`ifdef SIGMA_NP_MEAN_EN
  logic [DATA_W:0]   mean_out;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int p0;

  sigma_np #(.DATA_W(DATA_W), .LOG2_N_MAX(LOG2_N_MAX)) dut (
    .clk(clk),
    .res(res),
    .data_in(data_in),
    .syn_in(syn_in),
    .fmt_sm(fmt_sm),
    .log2_n(log2_n),
    .clr(clr),
    .data_out(data_out),
    .syn_out(syn_out)
`ifdef SIGMA_NP_MEAN_EN
    ,
    .mean_out(mean_out)
`endif
  );

  always #5 clk = ~clk;

  // Count syn_out cycles, sampled away from the active edge.
  always @(negedge clk) begin
    if (syn_out) pulses++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // Present one sample; called at #1 after a rising edge, returns likewise.
  task automatic put(input logic [7:0] v, input logic f, input int hold);
    data_in = v;
    fmt_sm  = f;
    syn_in  = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    syn_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic put_n(input logic [7:0] v, input logic f, input int n);
    for (int i = 0; i < n; i++) put(v, f, 1);
  endtask

  initial begin
    #1;
    check_eq("rst_data", 32'(data_out), 32'h0);
    check_eq("rst_syn", 32'(syn_out), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    res = 1'b0;
    log2_n = 3'd4;
    @(posedge clk);
    #1;

    // 16 x 0x7F sign-magnitude, with explicit latency on the last sample
    p0 = pulses;
    put_n(8'h7F, 1'b1, 15);
    check_eq("no_early_pulse", 32'(pulses - p0), 32'd0);
    data_in = 8'h7F;
    syn_in = 1'b1;
    @(negedge clk);
    check_eq("lat_pre", 32'(syn_out), 32'h0);
    @(posedge clk);
    #1;
    check_eq("lat_hit", 32'(syn_out), 32'h1);
    syn_in = 1'b0;
    @(posedge clk);
    #1;
    check_eq("lat_drop", 32'(syn_out), 32'h0);
    check_eq("sm_7f_sum", 32'(data_out), 32'h7F0);
    check_eq("sm_7f_pulses", 32'(pulses - p0), 32'd1);

    put_n(8'h81, 1'b1, 16);
    check_eq("sm_81_sum", 32'(data_out), 32'hFF0);

    // -0 contributes nothing
    put_n(8'h01, 1'b1, 15);
    put(8'h80, 1'b1, 1);
    check_eq("sm_neg0", 32'(data_out), 32'h00F);

    // mixed formats in one block: 8*(-1) + 8*(-127) = -1024
    put_n(8'h81, 1'b1, 8);
    put_n(8'h81, 1'b0, 8);
    check_eq("mixed_fmt", 32'(data_out), 32'hC00);

    put_n(8'h81, 1'b0, 16);
    check_eq("tc_81_sum", 32'(data_out), 32'h810);
    put_n(8'h80, 1'b0, 16);
    check_eq("tc_80_sum", 32'(data_out), 32'h800);

    // length change mid-block is ignored
    log2_n = 3'd2;
    p0 = pulses;
    put(8'd1, 1'b0, 1);
    put(8'd2, 1'b0, 1);
    log2_n = 3'd4;
    put(8'd3, 1'b0, 1);
    put(8'd4, 1'b0, 1);
    check_eq("len_frozen_sum", 32'(data_out), 32'd10);
    check_eq("len_frozen_pulse", 32'(pulses - p0), 32'd1);
    p0 = pulses;
    put_n(8'd2, 1'b0, 4);
    check_eq("len_next_hold", 32'(data_out), 32'd10);
    put_n(8'd2, 1'b0, 12);
    check_eq("len_next_sum", 32'(data_out), 32'd32);
    check_eq("len_next_pulse", 32'(pulses - p0), 32'd1);

    // clr coincident with the 6th strobe
    put_n(8'd7, 1'b0, 5);
    data_in = 8'd7;
    syn_in = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    check_eq("clr_syn", 32'(syn_out), 32'h0);
    check_eq("clr_hold", 32'(data_out), 32'd32);
    clr = 1'b0;
    syn_in = 1'b0;
    @(posedge clk);
    #1;
    p0 = pulses;
    put_n(8'd1, 1'b0, 15);
    check_eq("clr_no_pulse", 32'(pulses - p0), 32'd0);
    put(8'd1, 1'b0, 1);
    check_eq("clr_sum", 32'(data_out), 32'd16);
    check_eq("clr_pulse", 32'(pulses - p0), 32'd1);

    // strobe held high for 10 cycles counts once
    p0 = pulses;
    for (int i = 0; i < 16; i++) put(8'd2, 1'b0, 10);
    check_eq("held_sum", 32'(data_out), 32'd32);
    check_eq("held_pulse", 32'(pulses - p0), 32'd1);

    // requested length above maximum clamps to 16
    log2_n = 3'd7;
    p0 = pulses;
    put_n(8'd3, 1'b0, 15);
    check_eq("clamp_no_pulse", 32'(pulses - p0), 32'd0);
    put(8'd3, 1'b0, 1);
    check_eq("clamp_sum", 32'(data_out), 32'd48);

    // length 1: every strobe completes
    log2_n = 3'd0;
    p0 = pulses;
    put(8'h85, 1'b0, 1);
    check_eq("len0_tc", 32'(data_out), 32'hF85);
    put(8'h85, 1'b1, 1);
    check_eq("len0_sm", 32'(data_out), 32'hFFB);
    check_eq("len0_pulses", 32'(pulses - p0), 32'd2);

`ifdef SIGMA_NP_MEAN_EN
    log2_n = 3'd2;
    put(8'd3, 1'b0, 1);
    put_n(8'd4, 1'b0, 3);
    check_eq("mean_sum", 32'(data_out), 32'd15);
    check_eq("mean_val", 32'(mean_out), 32'd4);
`endif

    // asynchronous reset mid-block
    log2_n = 3'd4;
    @(posedge clk);
    #1;
    put_n(8'd5, 1'b0, 7);
    res = 1'b1;
    #1;
    check_eq("mid_rst_data", 32'(data_out), 32'h0);
    check_eq("mid_rst_syn", 32'(syn_out), 32'h0);
    @(posedge clk);
    #1;
    res = 1'b0;
    @(posedge clk);
    #1;
    put_n(8'd1, 1'b0, 16);
    check_eq("post_rst_sum", 32'(data_out), 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
